// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcode/funct
// constants, datapath select encodings and the decoded instruction classes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXE_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXE_R    = 4'd7,
        S_ALU_WB   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    typedef enum logic [3:0] {
        C_RTYPE_ALU,
        C_IMM_ALU,
        C_LUI,
        C_LOAD,
        C_STORE,
        C_BRANCH_EQ,
        C_BRANCH_NE,
        C_JUMP,
        C_JUMP_LINK,
        C_ILLEGAL
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [3:0] ALU_ADD  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_ZERO = 4'b1001;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_TRAP = 2'b11;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] RFIN_PC  = 2'b00;
    localparam logic [1:0] RFIN_DR  = 2'b01;
    localparam logic [1:0] RFIN_ALU = 2'b10;

    localparam logic [1:0] RFOUT_RD = 2'b00;
    localparam logic [1:0] RFOUT_RT = 2'b01;
    localparam logic [1:0] RFOUT_RA = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct classifier feeding the controller FSM.
// bne is only recognised when BNE_EN is set; otherwise it is illegal.
module ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter bit BNE_EN = 1'b1
) (
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] cls_o
);

    instr_class_e cls_d;

    always_comb begin
        cls_d = C_ILLEGAL;
        case (op_i)
            OP_RTYPE: begin
                if (funct_i == FN_ADDU || funct_i == FN_SUBU) begin
                    cls_d = C_RTYPE_ALU;
                end
            end
            OP_ORI: cls_d = C_IMM_ALU;
            OP_LUI: cls_d = C_LUI;
            OP_LW:  cls_d = C_LOAD;
            OP_SW:  cls_d = C_STORE;
            OP_BEQ: cls_d = C_BRANCH_EQ;
            OP_BNE: cls_d = BNE_EN ? C_BRANCH_NE : C_ILLEGAL;
            OP_J:   cls_d = C_JUMP;
            OP_JAL: cls_d = C_JUMP_LINK;
            default: cls_d = C_ILLEGAL;
        endcase
        cls_o = cls_d;
    end

endmodule

// File: rtl/multicycle_ctrl_v2.sv
// Multicycle MIPS control FSM with memory wait handshakes and illegal-op trap.
// The state register is the only storage; every output decodes from state and inputs.
module multicycle_ctrl_v2
    import mips_ctrl_pkg::*;
#(
    parameter bit WAIT_EN = 1'b1,
    parameter bit TRAP_EN = 1'b1,
    parameter bit BNE_EN  = 1'b1,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               im_ready,
    input  logic               dm_ready,
    output logic               B_sel,
    output logic [1:0]         RFin_sel,
    output logic [1:0]         RFout_sel,
    output logic               RFWr,
    output logic               DMWr,
    output logic               PCWr,
    output logic               IRWr,
    output logic [1:0]         npcop,
    output logic [1:0]         extop,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal,
    output logic [3:0]         state_o
);

    state_e       state_q;
    state_e       state_d;
    instr_class_e cls;
    logic [3:0]   cls_raw;
    logic [3:0]   alu_d;
    logic         im_ok;
    logic         dm_ok;

    ctrl_decode #(
        .BNE_EN (BNE_EN)
    ) u_decode (
        .op_i    (op),
        .funct_i (funct),
        .cls_o   (cls_raw)
    );

    assign cls   = instr_class_e'(cls_raw);
    assign im_ok = WAIT_EN ? im_ready : 1'b1;
    assign dm_ok = WAIT_EN ? dm_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        B_sel     = 1'b0;
        RFin_sel  = RFIN_PC;
        RFout_sel = RFOUT_RD;
        RFWr      = 1'b0;
        DMWr      = 1'b0;
        PCWr      = 1'b0;
        IRWr      = 1'b0;
        npcop     = NPC_PC4;
        extop     = EXT_ZERO;
        alu_d     = ALU_ZERO;
        illegal   = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                PCWr = im_ok;
                IRWr = im_ok;
                if (im_ok) state_d = S_DECODE;
            end

            S_DECODE: begin
                case (cls)
                    C_RTYPE_ALU, C_IMM_ALU, C_LUI: state_d = S_EXE_R;
                    C_LOAD, C_STORE:               state_d = S_EXE_ADDR;
                    C_BRANCH_EQ, C_BRANCH_NE:      state_d = S_BRANCH;
                    C_JUMP, C_JUMP_LINK:           state_d = S_JUMP;
                    default:                       state_d = TRAP_EN ? S_TRAP : S_FETCH;
                endcase
            end

            S_EXE_ADDR: begin
                B_sel   = 1'b1;
                extop   = EXT_SIGN;
                alu_d   = ALU_ADD;
                state_d = (cls == C_LOAD) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                if (dm_ok) state_d = S_MEM_WB;
            end

            S_MEM_WB: begin
                RFWr      = 1'b1;
                RFin_sel  = RFIN_DR;
                RFout_sel = RFOUT_RT;
                state_d   = S_FETCH;
            end

            // DMWr is held for the whole wait so the memory sees a stable request.
            S_MEM_WR: begin
                extop = EXT_SIGN;
                DMWr  = 1'b1;
                if (dm_ok) state_d = S_FETCH;
            end

            S_EXE_R: begin
                case (cls)
                    C_RTYPE_ALU: alu_d = (funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
                    C_IMM_ALU: begin
                        B_sel = 1'b1;
                        extop = EXT_ZERO;
                        alu_d = ALU_OR;
                    end
                    C_LUI: begin
                        B_sel = 1'b1;
                        extop = EXT_LUI;
                        alu_d = ALU_OR;
                    end
                    default: alu_d = ALU_ZERO;
                endcase
                state_d = S_ALU_WB;
            end

            S_ALU_WB: begin
                RFWr      = 1'b1;
                RFin_sel  = RFIN_ALU;
                RFout_sel = (cls == C_RTYPE_ALU) ? RFOUT_RD : RFOUT_RT;
                state_d   = S_FETCH;
            end

            S_BRANCH: begin
                alu_d   = ALU_SUB;
                npcop   = NPC_BR;
                PCWr    = (cls == C_BRANCH_NE) ? !zero : zero;
                state_d = S_FETCH;
            end

            S_JUMP: begin
                PCWr  = 1'b1;
                npcop = NPC_JMP;
                if (cls == C_JUMP_LINK) begin
                    RFWr      = 1'b1;
                    RFin_sel  = RFIN_PC;
                    RFout_sel = RFOUT_RA;
                end
                state_d = S_FETCH;
            end

            S_TRAP: begin
                illegal = 1'b1;
                PCWr    = 1'b1;
                npcop   = NPC_TRAP;
                state_d = S_FETCH;
            end

            default: state_d = S_IDLE;
        endcase

        aluop = ALUOP_W'(alu_d);
    end

    assign state_o = state_q;

endmodule
